// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : FSM state encoding and width helpers shared by the FIR core.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } fir_state_t;

    function automatic int fir_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Product width plus enough growth bits to sum TAPS full-scale products.
    function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + fir_clog2(taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac
// Brief    : Signed multiplier feeding an accumulator with clear/enable.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              i_clr,
    input  logic                                              i_en,
    input  logic signed [DATA_W-1:0]                          i_sample,
    input  logic signed [COEF_W-1:0]                          i_coef,
    output logic signed [fir_acc_w(DATA_W, COEF_W, TAPS)-1:0] o_acc
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod     = i_sample * i_coef;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Clear has priority so a new sample always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/fir_param_core.sv
`default_nettype none
// ============================================================================
// Module   : fir_param_core
// Brief    : Sequential single-MAC FIR filter with loadable coefficients.
//            Define FIR_SAT_EN to saturate out_data instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module fir_param_core
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic signed [COEF_W-1:0] cfg_data,
    output logic                     cfg_busy,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_ovf
);

    localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, TAPS);
    localparam int IDX_W = (fir_clog2(TAPS) < 1) ? 1 : fir_clog2(TAPS);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(TAPS - 1);

    fir_state_t r_state;
    fir_state_t w_next_state;

    logic [IDX_W-1:0]         r_idx;
    logic signed [COEF_W-1:0] r_coef [TAPS];
    logic signed [DATA_W-1:0] r_dly  [TAPS];

    logic                     w_accept;
    logic                     w_load_wr;
    logic                     w_idx_clr;
    logic                     w_idx_inc;
    logic                     w_mac_clr;
    logic                     w_mac_en;
    logic                     w_out_upd;

    logic signed [COEF_W-1:0] w_tap_coef;
    logic signed [DATA_W-1:0] w_tap_sample;
    logic signed [ACC_W-1:0]  w_acc;
    logic                     w_ovf;
    logic [OUT_W-1:0]         w_out;

    logic                     r_out_valid;
    logic [OUT_W-1:0]         r_out_data;
    logic                     r_out_ovf;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_wr    = 1'b0;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_mac_clr    = 1'b0;
        w_mac_en     = 1'b0;
        w_out_upd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Coefficient load takes precedence over a pending sample.
                if (cfg_start) begin
                    w_idx_clr    = 1'b1;
                    w_next_state = ST_LOAD;
                end else if (in_valid) begin
                    w_accept     = 1'b1;
                    w_idx_clr    = 1'b1;
                    w_mac_clr    = 1'b1;
                    w_next_state = ST_MAC;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    w_idx_clr = 1'b1;
                end else if (cfg_valid) begin
                    w_load_wr = 1'b1;
                    w_idx_inc = 1'b1;
                    if (r_idx == C_LAST_IDX) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_MAC: begin
                w_mac_en  = 1'b1;
                w_idx_inc = 1'b1;
                if (r_idx == C_LAST_IDX) begin
                    w_next_state = ST_OUT;
                end
            end
            ST_OUT: begin
                w_out_upd    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_idx_clr) begin
            r_idx <= '0;
        end else if (w_idx_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient store and delay line (loads leave samples untouched)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (w_load_wr && (r_idx == IDX_W'(k))) begin
                    r_coef[k] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_dly[k] <= '0;
            end
        end else if (w_accept) begin
            r_dly[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
        end
    end

    always_comb begin
        w_tap_coef   = '0;
        w_tap_sample = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_tap_coef   = r_coef[k];
                w_tap_sample = r_dly[k];
            end
        end
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_mac (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_mac_clr),
        .i_en     (w_mac_en),
        .i_sample (w_tap_sample),
        .i_coef   (w_tap_coef),
        .o_acc    (w_acc)
    );

    // ------------------------------------------------------------------
    // Range check and output formatting
    // ------------------------------------------------------------------
    generate
        if (OUT_W < ACC_W) begin : g_ovf_detect
            // In range only when every bit above the OUT_W sign bit matches it.
            logic [ACC_W-OUT_W:0] w_hi;
            assign w_hi  = w_acc[ACC_W-1:OUT_W-1];
            assign w_ovf = !((&w_hi) || !(|w_hi));
        end else begin : g_ovf_none
            assign w_ovf = 1'b0;
        end
    endgenerate

`ifdef FIR_SAT_EN
    localparam logic [OUT_W-1:0] C_OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] C_OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    assign w_out = w_ovf ? (w_acc[ACC_W-1] ? C_OUT_MIN : C_OUT_MAX)
                         : w_acc[OUT_W-1:0];
`else
    assign w_out = w_acc[OUT_W-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= w_out_upd;
            if (w_out_upd) begin
                r_out_data <= w_out;
                r_out_ovf  <= w_ovf;
            end
        end
    end

    assign cfg_busy  = (r_state == ST_LOAD);
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fir_param_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_param_core
// Brief    : Directed self-checking bench for fir_param_core (default params).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_param_core;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 11;

`ifdef FIR_SAT_EN
    localparam logic signed [OUT_W-1:0] EXP_POS = 11'sd1023;
    localparam logic signed [OUT_W-1:0] EXP_NEG = -11'sd1024;
`else
    localparam logic signed [OUT_W-1:0] EXP_POS = 11'h404;
    localparam logic signed [OUT_W-1:0] EXP_NEG = 11'h200;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     cfg_start;
    logic                     cfg_valid;
    logic signed [COEF_W-1:0] cfg_data;
    logic                     cfg_busy;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_ovf;

    int checks = 0;
    int errors = 0;

    fir_param_core #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coefs(input logic signed [COEF_W-1:0] c0, input logic signed [COEF_W-1:0] c1,
                              input logic signed [COEF_W-1:0] c2, input logic signed [COEF_W-1:0] c3);
        logic signed [COEF_W-1:0] tbl [4];
        tbl = '{c0, c1, c2, c3};
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = tbl[k];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_data  = '0;
    endtask

    // Offers one sample from IDLE and waits (bounded) for its result strobe.
    // timing_ok: accepted when ready, in_ready low while busy, strobe TAPS+1
    // edges after acceptance and exactly one cycle wide.
    task automatic send_sample(input logic signed [DATA_W-1:0] x, output logic signed [OUT_W-1:0] y,
                               output logic ovf, output bit timing_ok);
        int lat;
        bit seen;
        timing_ok = (in_ready === 1'b1);
        in_valid  = 1'b1;
        in_data   = x;
        tick();
        in_valid  = 1'b0;
        in_data   = '0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (in_ready !== 1'b0) timing_ok = 1'b0;
                tick();
                lat++;
            end
        end
        y   = out_data;
        ovf = out_ovf;
        if (!seen || lat != TAPS + 1) timing_ok = 1'b0;
        tick();
        if (out_valid !== 1'b0) timing_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 11'sd0) begin errors++; $display("FAIL reset_out_data got %0d expected 0", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b expected 0", out_ovf); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy got %b expected 0", cfg_busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_impulse();
        logic signed [DATA_W-1:0] samples [5];
        logic signed [OUT_W-1:0]  expect_y [5];
        logic signed [OUT_W-1:0]  y;
        logic ovf;
        bit tok;
        samples  = '{8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        expect_y = '{11'sd1, 11'sd2, 11'sd3, 11'sd4, 11'sd0};
        load_coefs(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL impulse_load_done cfg_busy got %b expected 0", cfg_busy); end
        for (int i = 0; i < 5; i++) begin
            send_sample(samples[i], y, ovf, tok);
            checks++; if (y !== expect_y[i]) begin errors++; $display("FAIL impulse_y[%0d] got %0d expected %0d", i, y, expect_y[i]); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL impulse_ovf[%0d] got %b expected 0", i, ovf); end
            checks++; if (tok !== 1'b1) begin errors++; $display("FAIL impulse_timing[%0d] got %b expected 1", i, tok); end
            if (i == 0) begin
                tick();
                tick();
                checks++; if (out_data !== 11'sd1) begin errors++; $display("FAIL impulse_hold got %0d expected 1", out_data); end
            end
        end
    endtask

    task automatic test_load_restart();
        logic signed [OUT_W-1:0] y;
        logic ovf;
        bit tok;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b expected 1", cfg_busy); end
        cfg_valid = 1'b1; cfg_data = 8'sd5; tick();
        cfg_data = 8'sd6; tick();
        cfg_start = 1'b1; cfg_data = 8'sd9; tick();
        cfg_start = 1'b0;
        cfg_data = 8'sd1; tick();
        cfg_data = 8'sd0; tick();
        tick();
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL restart_busy_before_last got %b expected 1", cfg_busy); end
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL restart_busy_after_last got %b expected 0", cfg_busy); end
        send_sample(-8'sd3, y, ovf, tok);
        checks++; if (y !== -11'sd3) begin errors++; $display("FAIL restart_y got %0d expected -3", y); end
        checks++; if (tok !== 1'b1) begin errors++; $display("FAIL restart_timing got %b expected 1", tok); end
        load_coefs(8'sd0, 8'sd1, 8'sd0, 8'sd0);
        send_sample(8'sd0, y, ovf, tok);
        checks++; if (y !== -11'sd3) begin errors++; $display("FAIL load_keeps_delay got %0d expected -3", y); end
    endtask

    task automatic test_overflow();
        logic signed [OUT_W-1:0] y;
        logic ovf;
        bit tok;
        load_coefs(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        for (int i = 0; i < 4; i++) send_sample(8'sd127, y, ovf, tok);
        checks++; if (y !== EXP_POS) begin errors++; $display("FAIL ovf_pos_y got %0d expected %0d", y, EXP_POS); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos_flag got %b expected 1", ovf); end
        for (int i = 0; i < 4; i++) send_sample(8'sh80, y, ovf, tok);
        checks++; if (y !== EXP_NEG) begin errors++; $display("FAIL ovf_neg_y got %0d expected %0d", y, EXP_NEG); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_neg_flag got %b expected 1", ovf); end
    endtask

    task automatic test_cfg_priority();
        logic signed [OUT_W-1:0] y;
        logic ovf;
        bit tok;
        int strobes;
        logic signed [COEF_W-1:0] tbl [4];
        tbl = '{8'sd0, 8'sd1, 8'sd0, 8'sd0};
        strobes   = 0;
        cfg_start = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'sd5;
        tick();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL prio_busy got %b expected 1", cfg_busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL prio_in_ready got %b expected 0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            if (out_valid === 1'b1) strobes++;
            cfg_valid = 1'b1;
            cfg_data  = tbl[k];
            tick();
        end
        cfg_valid = 1'b0;
        for (int k = 0; k < TAPS + 2; k++) begin
            if (out_valid === 1'b1) strobes++;
            tick();
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL prio_no_strobe got %0d expected 0", strobes); end
        send_sample(8'sd7, y, ovf, tok);
        checks++; if (y !== -11'sd128) begin errors++; $display("FAIL prio_sample_dropped got %0d expected -128", y); end
    endtask

    task automatic test_cfg_ignored_busy();
        bit busy_seen;
        busy_seen = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'sd2;
        tick();
        in_valid  = 1'b0;
        cfg_start = 1'b1;
        for (int k = 1; k <= TAPS; k++) begin
            tick();
            if (cfg_busy !== 1'b0) busy_seen = 1'b1;
        end
        cfg_start = 1'b0;
        tick();
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL cfg_in_mac busy got %b expected 0", busy_seen); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cfg_in_mac_strobe got %b expected 1", out_valid); end
        checks++; if (out_data !== 11'sd7) begin errors++; $display("FAIL cfg_in_mac_y got %0d expected 7", out_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic signed [OUT_W-1:0] y;
        logic ovf;
        bit tok;
        int guard;
        in_valid = 1'b1;
        in_data  = 8'sd10;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        checks++; if (guard != TAPS + 1) begin errors++; $display("FAIL b2b_first_latency got %0d expected %0d", guard, TAPS + 1); end
        checks++; if (out_data !== 11'sd2) begin errors++; $display("FAIL b2b_first_y got %0d expected 2", out_data); end
        send_sample(8'sd11, y, ovf, tok);
        checks++; if (tok !== 1'b1) begin errors++; $display("FAIL b2b_throughput got %b expected 1", tok); end
        checks++; if (y !== 11'sd10) begin errors++; $display("FAIL b2b_second_y got %0d expected 10", y); end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [OUT_W-1:0] y;
        logic ovf;
        bit tok;
        int strobes;
        strobes  = 0;
        in_valid = 1'b1;
        in_data  = 8'sd1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midmac_out_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 11'sd0) begin errors++; $display("FAIL midmac_out_data got %0d expected 0", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL midmac_out_ovf got %b expected 0", out_ovf); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL midmac_cfg_busy got %b expected 0", cfg_busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmac_in_ready got %b expected 1", in_ready); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < TAPS + 3; k++) begin
            if (out_valid === 1'b1) strobes++;
            tick();
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL midmac_no_strobe got %0d expected 0", strobes); end
        send_sample(8'sd1, y, ovf, tok);
        checks++; if (y !== 11'sd0) begin errors++; $display("FAIL midmac_coefs_cleared got %0d expected 0", y); end
        checks++; if (tok !== 1'b1) begin errors++; $display("FAIL midmac_timing got %b expected 1", tok); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_load_restart();
        test_overflow();
        test_cfg_priority();
        test_cfg_ignored_busy();
        test_back_to_back();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
